// File: rtl/alu_seq64_pkg.sv
// Shared definitions for the 64-bit sequencer over a 32-bit ALU:
// external ALU card codes, request op codes and sequencer states.
// Pure declarations, no logic.
package alu_seq64_pkg;

   // ALU card codes (function selects on alu_card)
   localparam logic [4:0] CARD_ADD   = 5'd1;
   localparam logic [4:0] CARD_ADDC  = 5'd2;
   localparam logic [4:0] CARD_SUB   = 5'd3;
   localparam logic [4:0] CARD_SUBC  = 5'd4;
   localparam logic [4:0] CARD_RSUB  = 5'd5;
   localparam logic [4:0] CARD_RSUBC = 5'd6;
   localparam logic [4:0] CARD_A     = 5'd7;
   localparam logic [4:0] CARD_B     = 5'd8;
   localparam logic [4:0] CARD_NOTA  = 5'd9;
   localparam logic [4:0] CARD_NOTB  = 5'd10;
   localparam logic [4:0] CARD_OR    = 5'd11;
   localparam logic [4:0] CARD_AND   = 5'd12;
   localparam logic [4:0] CARD_XNOR  = 5'd13;
   localparam logic [4:0] CARD_XOR   = 5'd14;
   localparam logic [4:0] CARD_NAND  = 5'd15;
   localparam logic [4:0] CARD_ZERO  = 5'd16;

   // Request op codes
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_RSUB = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_NAND = 3'd7;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_seq64_dec.sv
// Maps (op, half) to the ALU card and whether the op is carry-chained.
// Latency: combinational.
// Backpressure: none (pure decode).
module alu_seq64_dec
   import alu_seq64_pkg::*;
(
   input  logic [2:0] op,
   input  logic       half,
   output logic [4:0] card,
   output logic       use_carry
);

   // Arithmetic ops chain carry into the upper word; logic ops use one card for both halves
   always_comb begin
      card      = CARD_ZERO;
      use_carry = 1'b0;
      case (op)
         OP_ADD:  begin card = half ? CARD_ADDC  : CARD_ADD;  use_carry = 1'b1; end
         OP_SUB:  begin card = half ? CARD_SUBC  : CARD_SUB;  use_carry = 1'b1; end
         OP_RSUB: begin card = half ? CARD_RSUBC : CARD_RSUB; use_carry = 1'b1; end
         OP_AND:  card = CARD_AND;
         OP_OR:   card = CARD_OR;
         OP_XOR:  card = CARD_XOR;
         OP_XNOR: card = CARD_XNOR;
         OP_NAND: card = CARD_NAND;
         default: card = CARD_ZERO;
      endcase
   end

endmodule

// File: rtl/alu_seq64.sv
// 64-bit add/sub/logic built from two passes through an external 32-bit ALU.
// Latency: out_valid 3 cycles after accept; one request in flight, issue interval 4.
// Backpressure: result held in DONE until out_ready; in_ready low while busy, requests then ignored.
module alu_seq64
   import alu_seq64_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [63:0] opa,
   input  logic [63:0] opb,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result,
   output logic        carry,
   output logic        zero,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_cin,
   output logic [4:0]  alu_card,
   input  logic [31:0] alu_f,
   input  logic        alu_cout,
   input  logic        alu_zero
);

   state_t      state;
   logic [2:0]  op_q;
   logic [63:0] opa_q;
   logic [63:0] opb_q;
   logic [31:0] res_lo;
   logic        c_lo;
   logic        z_lo;

   logic        half;
   logic [4:0]  dec_card;
   logic        dec_use_carry;

   assign half      = (state == ST_HI);
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   alu_seq64_dec u_dec (
      .op        (op_q),
      .half      (half),
      .card      (dec_card),
      .use_carry (dec_use_carry)
   );

   // Drive the ALU from latched operands; parked at ZERO with zero operands when not sequencing
   always_comb begin
      alu_a    = 32'd0;
      alu_b    = 32'd0;
      alu_cin  = 1'b0;
      alu_card = CARD_ZERO;
      case (state)
         ST_LO: begin
            alu_a    = opa_q[31:0];
            alu_b    = opb_q[31:0];
            alu_card = dec_card;
         end
         ST_HI: begin
            alu_a    = opa_q[63:32];
            alu_b    = opb_q[63:32];
            alu_cin  = dec_use_carry & c_lo;
            alu_card = dec_card;
         end
         default: begin
            alu_a    = 32'd0;
            alu_b    = 32'd0;
            alu_cin  = 1'b0;
            alu_card = CARD_ZERO;
         end
      endcase
   end

   // Sequencer: accept, low word, high word, hold result until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_q   <= 3'd0;
         opa_q  <= 64'd0;
         opb_q  <= 64'd0;
         res_lo <= 32'd0;
         c_lo   <= 1'b0;
         z_lo   <= 1'b0;
         result <= 64'd0;
         carry  <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q  <= op;
                  opa_q <= opa;
                  opb_q <= opb;
                  state <= ST_LO;
               end
            end
            ST_LO: begin
               res_lo <= alu_f;
               c_lo   <= alu_cout;
               z_lo   <= alu_zero;
               state  <= ST_HI;
            end
            ST_HI: begin
               result <= {alu_f, res_lo};
               zero   <= z_lo & alu_zero;
               carry  <= dec_use_carry & alu_cout;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_seq64.md
ALU_SEQ64 -- requirements
Module: alu_seq64

Interface
REQ-001 The block SHALL have no parameters; all card codes and op codes SHALL come from the shared package.
REQ-002 The block SHALL use exactly one clock and an asynchronous, active-low reset, with ports ordered clk then rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op  input  3  operation: 0 ADD, 1 SUB (a-b), 2 RSUB (b-a), 3 AND, 4 OR, 5 XOR, 6 XNOR, 7 NAND.
REQ-008 opa, opb  input  64 each  operands.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  64  64-bit result.
REQ-012 carry  output  1  final carry-out, or not-borrow for subtracts.
REQ-013 zero  output  1  set when all 64 result bits are 0.
REQ-014 alu_a, alu_b  output  32 each  ALU operand words.
REQ-015 alu_cin  output  1  ALU carry-in.
REQ-016 alu_card  output  5  ALU function select.
REQ-017 alu_f  input  32  ALU result.
REQ-018 alu_cout  input  1  ALU carry-out.
REQ-019 alu_zero  input  1  ALU zero flag.

Function
REQ-020 ALU card codes SHALL be:
- 1 ADD, 2 ADDC, 3 SUB, 4 SUBC, 5 RSUB, 6 RSUBC
- 7 A, 8 B, 9 NOTA, 10 NOTB, 11 OR, 12 AND, 13 XNOR, 14 XOR, 15 NAND, 16 ZERO
REQ-021 Subtract semantics SHALL be x + ~y + cin, with cout = 1 meaning no borrow.
REQ-022 The FSM SHALL have the states IDLE, LO, HI and DONE, one-hot or binary encoded.
REQ-023 In IDLE: in_ready=1. On in_valid, the block SHALL latch op, opa and opb, then go to LO.
REQ-024 In LO: drive alu_a=opa[31:0], alu_b=opb[31:0], alu_cin=0, card = ADD/SUB/RSUB, or the logic card for logic ops. At the edge, latch res_lo=alu_f, c_lo=alu_cout, z_lo=alu_zero; go to HI.
REQ-025 In HI: drive the upper words. Card = ADDC/SUBC/RSUBC with alu_cin=c_lo for arithmetic ops; for logic ops, same card with alu_cin=0. At the edge, latch result={alu_f,res_lo} and zero=z_lo&alu_zero. For arithmetic ops latch carry=alu_cout; for logic ops carry=0. Go to DONE.
REQ-026 In DONE: out_valid=1, and result/carry/zero SHALL stay stable until out_ready=1, then go to IDLE.
REQ-027 Latency: with out_ready held high, out_valid SHALL be high exactly 3 cycles after the accepting edge. Minimum issue interval SHALL be 4 cycles.
REQ-028 in_ready SHALL be 0 in LO, HI and DONE. in_valid in those states SHALL be ignored and not queued.
REQ-029 In IDLE and DONE, the ALU outputs SHALL be alu_a=0, alu_b=0, alu_cin=0, alu_card=16 (ZERO).
REQ-030 Operands latched at accept SHALL be used for both halves; later changes on opa/opb SHALL have no effect.
REQ-031 alu_* outputs SHALL be combinational from state and latched operands. alu_f, alu_cout and alu_zero SHALL be sampled only at the LO and HI edges.

Reset
REQ-032 On rst_n=0: state=IDLE; result=0, carry=0, zero=0, out_valid=0; internal latches cleared.
REQ-033 Reset asserted in LO, HI or DONE SHALL abort the operation; no out_valid for it SHALL follow.
REQ-034 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-035 A shared package SHALL hold the 5-bit card constants, the 3-bit op constants and the state enum.
REQ-036 One combinational sub-module, alu_seq64_dec, SHALL map (op, half) to {card, use_carry}.

Verification
REQ-037 Carry across the word boundary: ADD opa=0x00000000_FFFFFFFF, opb=1 -> result=0x00000001_00000000, carry=0, zero=0, out_valid 3 cycles after accept.
REQ-038 Equal operands: SUB opa=opb=0x12345678_9ABCDEF0 -> result=0, zero=1, carry=1.
REQ-039 Borrow case: RSUB opa=5, opb=3 -> result=0xFFFFFFFF_FFFFFFFE, carry=0, zero=0.
REQ-040 Logic op: AND opa=0xFFFF0000_0000FFFF, opb=0x0000FFFF_FFFF0000 -> result=0, zero=1, carry=0. Probe alu_card=12 in both LO and HI.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> IDLE next cycle.
REQ-042 Reset mid-operation: assert rst_n=0 while in HI -> out_valid=0, result=0, in_ready=1 after release, and no stale result appears.
